issue_queue: RTL and testbench

//  Parametrised reservation station; successor to the fixed 3-wide ADD/MUL/AGU RS in the OoO core.

---
 rtl/issue_queue_pkg.sv | 30 +++
 rtl/issue_queue_if.sv | 51 +++++
 rtl/issue_queue_age_select.sv | 33 +++
 rtl/issue_queue.sv | 146 ++++++++++++++
 tb/tb_issue_queue.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_pkg.sv
// rtl/issue_queue_pkg.sv - shared widths, FU classes and entry layout for the issue queue
package issue_queue_pkg;

    localparam int P_W   = 5;
    localparam int TAG_W = 5;
    localparam int IMM_W = 5;

    typedef enum logic [1:0] {
        FU_ADD = 2'd0,
        FU_MUL = 2'd1,
        FU_AGU = 2'd2,
        FU_LS  = 2'd3
    } fu_type_e;

    typedef struct packed {
        logic [P_W-1:0]   pa;
        logic [P_W-1:0]   pb;
        logic [P_W-1:0]   pw;
        logic [IMM_W-1:0] imm;
        logic [TAG_W-1:0] tag_rob;
    } iq_payload_t;

    typedef struct packed {
        logic        valid;
        logic        rdy_a;
        logic        rdy_b;
        iq_payload_t pl;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - dispatch, broadcast, control and issue bundle of one issue queue
interface issue_queue_if
    import issue_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DISPATCH_W = 3,
    parameter int NUM_WB     = 3
);
    logic                                 flush;
    logic                                 freeze_front;
    logic                                 freeze_back;
    logic [DISPATCH_W-1:0]                disp_valid;
    logic [DISPATCH_W-1:0][1:0]           disp_fu_type;
    logic [DISPATCH_W-1:0][P_W-1:0]       disp_pa;
    logic [DISPATCH_W-1:0][P_W-1:0]       disp_pb;
    logic [DISPATCH_W-1:0][P_W-1:0]       disp_pw;
    logic [DISPATCH_W-1:0]                disp_rdy_a;
    logic [DISPATCH_W-1:0]                disp_rdy_b;
    logic [DISPATCH_W-1:0][IMM_W-1:0]     disp_imm;
    logic [DISPATCH_W-1:0][TAG_W-1:0]     disp_tag_rob;
    logic [NUM_WB-1:0]                    wb_valid;
    logic [NUM_WB-1:0][P_W-1:0]           wb_pw;
    logic [TAG_W-1:0]                     ptr_old;
    logic                                 full;
    logic [$clog2(DEPTH):0]               free_cnt;
    logic                                 iss_valid;
    logic [P_W-1:0]                       iss_pa;
    logic [P_W-1:0]                       iss_pb;
    logic [P_W-1:0]                       iss_pw;
    logic [IMM_W-1:0]                     iss_imm;
    logic [TAG_W-1:0]                     iss_tag_rob;

    modport slave (
        input  flush, freeze_front, freeze_back,
        input  disp_valid, disp_fu_type, disp_pa, disp_pb, disp_pw,
        input  disp_rdy_a, disp_rdy_b, disp_imm, disp_tag_rob,
        input  wb_valid, wb_pw, ptr_old,
        output full, free_cnt,
        output iss_valid, iss_pa, iss_pb, iss_pw, iss_imm, iss_tag_rob
    );

    modport master (
        output flush, freeze_front, freeze_back,
        output disp_valid, disp_fu_type, disp_pa, disp_pb, disp_pw,
        output disp_rdy_a, disp_rdy_b, disp_imm, disp_tag_rob,
        output wb_valid, wb_pw, ptr_old,
        input  full, free_cnt,
        input  iss_valid, iss_pa, iss_pb, iss_pw, iss_imm, iss_tag_rob
    );

endinterface

// File: rtl/issue_queue_age_select.sv
// rtl/issue_queue_age_select.sv - oldest-first argmin over eligible entries, age relative to ROB head
module issue_queue_age_select
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            eligible,
    input  logic [DEPTH-1:0][TAG_W-1:0] tag_rob,
    input  logic [TAG_W-1:0]            ptr_old,
    output logic [DEPTH-1:0]            onehot,
    output logic                        any
);

    always_comb begin
        logic [TAG_W-1:0] best_age;
        logic [TAG_W-1:0] age;
        onehot   = '0;
        any      = 1'b0;
        best_age = '1;
        age      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Modulo subtraction makes wrapped tags behind ptr_old count as young.
            age = tag_rob[i] - ptr_old;
            if (eligible[i] && (!any || age < best_age)) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                any       = 1'b1;
                best_age  = age;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - reservation station for one FU class, oldest-ready-first single issue
// Optional WAKEUP_BYPASS_EN: this-cycle broadcasts also count toward eligibility.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int       DEPTH      = 8,
    parameter int       DISPATCH_W = 3,
    parameter int       NUM_WB     = 3,
    parameter fu_type_e FU_TYPE    = FU_ADD
) (
    input logic          clk,
    input logic          rst,
    issue_queue_if.slave iq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    iq_entry_t [DEPTH-1:0]            ent_q, ent_d;
    logic                             iss_valid_q, iss_valid_d;
    iq_payload_t                      iss_pl_q, iss_pl_d;
    iq_payload_t                      sel_pl;
    logic [DEPTH-1:0]                 elig;
    logic [DEPTH-1:0]                 sel_oh;
    logic                             sel_any;
    logic [DEPTH-1:0][TAG_W-1:0]      ent_tag;
    logic [CNT_W-1:0]                 free_cnt;

    function automatic logic wb_hit(input logic [NUM_WB-1:0] v,
                                    input logic [NUM_WB-1:0][P_W-1:0] pw,
                                    input logic [P_W-1:0] src);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) hit = hit | (v[k] && (pw[k] == src));
        return hit;
    endfunction

    always_comb begin
        free_cnt = CNT_W'(DEPTH);
        for (int i = 0; i < DEPTH; i++)
            if (ent_q[i].valid) free_cnt = free_cnt - CNT_W'(1);
    end

    assign iq.free_cnt = free_cnt;
    assign iq.full     = free_cnt < CNT_W'(DISPATCH_W);

    // Only registered valids participate, so an entry written this cycle can never be picked.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_tag[i] = ent_q[i].pl.tag_rob;
`ifdef WAKEUP_BYPASS_EN
            elig[i] = ent_q[i].valid
                   && (ent_q[i].rdy_a || wb_hit(iq.wb_valid, iq.wb_pw, ent_q[i].pl.pa))
                   && (ent_q[i].rdy_b || wb_hit(iq.wb_valid, iq.wb_pw, ent_q[i].pl.pb));
`else
            elig[i] = ent_q[i].valid && ent_q[i].rdy_a && ent_q[i].rdy_b;
`endif
        end
    end

    issue_queue_age_select #(.DEPTH(DEPTH)) u_age_select (
        .eligible (elig),
        .tag_rob  (ent_tag),
        .ptr_old  (iq.ptr_old),
        .onehot   (sel_oh),
        .any      (sel_any)
    );

    always_comb begin
        sel_pl = '0;
        for (int i = 0; i < DEPTH; i++)
            if (sel_oh[i]) sel_pl = ent_q[i].pl;
    end

    always_comb begin
        logic [DEPTH-1:0] taken;
        logic             placed;
        ent_d       = ent_q;
        iss_valid_d = iss_valid_q;
        iss_pl_d    = iss_pl_q;
        taken       = '0;
        placed      = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                ent_d[i].rdy_a = ent_q[i].rdy_a | wb_hit(iq.wb_valid, iq.wb_pw, ent_q[i].pl.pa);
                ent_d[i].rdy_b = ent_q[i].rdy_b | wb_hit(iq.wb_valid, iq.wb_pw, ent_q[i].pl.pb);
            end
        end

        if (!iq.freeze_back) begin
            iss_valid_d = sel_any;
            iss_pl_d    = sel_pl;
            for (int i = 0; i < DEPTH; i++)
                if (sel_oh[i]) ent_d[i].valid = 1'b0;
        end

        // Free slots come from registered valids; an entry issued this cycle is not reused yet.
        if (!iq.freeze_front && !iq.full) begin
            for (int s = 0; s < DISPATCH_W; s++) begin
                if (iq.disp_valid[s] && (iq.disp_fu_type[s] == FU_TYPE)) begin
                    placed = 1'b0;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (!placed && !ent_q[i].valid && !taken[i]) begin
                            taken[i]            = 1'b1;
                            placed              = 1'b1;
                            ent_d[i].valid      = 1'b1;
                            ent_d[i].rdy_a      = iq.disp_rdy_a[s] | wb_hit(iq.wb_valid, iq.wb_pw, iq.disp_pa[s]);
                            ent_d[i].rdy_b      = iq.disp_rdy_b[s] | wb_hit(iq.wb_valid, iq.wb_pw, iq.disp_pb[s]);
                            ent_d[i].pl.pa      = iq.disp_pa[s];
                            ent_d[i].pl.pb      = iq.disp_pb[s];
                            ent_d[i].pl.pw      = iq.disp_pw[s];
                            ent_d[i].pl.imm     = iq.disp_imm[s];
                            ent_d[i].pl.tag_rob = iq.disp_tag_rob[s];
                        end
                    end
                end
            end
        end

        if (iq.flush) begin
            ent_d       = '0;
            iss_valid_d = 1'b0;
            iss_pl_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_pl_q    <= '0;
        end else begin
            ent_q       <= ent_d;
            iss_valid_q <= iss_valid_d;
            iss_pl_q    <= iss_pl_d;
        end
    end

    assign iq.iss_valid   = iss_valid_q;
    assign iq.iss_pa      = iss_pl_q.pa;
    assign iq.iss_pb      = iss_pl_q.pb;
    assign iq.iss_pw      = iss_pl_q.pw;
    assign iq.iss_imm     = iss_pl_q.imm;
    assign iq.iss_tag_rob = iss_pl_q.tag_rob;

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed self-checking bench for issue_queue
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = 3;
    localparam int NWB   = 3;
`ifdef WAKEUP_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    issue_queue_if #(.DEPTH(DEPTH), .DISPATCH_W(DW), .NUM_WB(NWB)) iq ();

    issue_queue #(
        .DEPTH      (DEPTH),
        .DISPATCH_W (DW),
        .NUM_WB     (NWB),
        .FU_TYPE    (FU_ADD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .iq  (iq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        iq.flush        = 1'b0;
        iq.freeze_front = 1'b0;
        iq.freeze_back  = 1'b0;
        iq.disp_valid   = '0;
        iq.disp_fu_type = '0;
        iq.disp_pa      = '0;
        iq.disp_pb      = '0;
        iq.disp_pw      = '0;
        iq.disp_rdy_a   = '0;
        iq.disp_rdy_b   = '0;
        iq.disp_imm     = '0;
        iq.disp_tag_rob = '0;
        iq.wb_valid     = '0;
        iq.wb_pw        = '0;
    endtask

    task automatic put(input int s, input logic [1:0] fu, input logic [4:0] pa, input logic [4:0] pb,
                       input logic [4:0] pw, input logic ra, input logic rb,
                       input logic [4:0] imm, input logic [4:0] tag);
        iq.disp_valid[s]   = 1'b1;
        iq.disp_fu_type[s] = fu;
        iq.disp_pa[s]      = pa;
        iq.disp_pb[s]      = pb;
        iq.disp_pw[s]      = pw;
        iq.disp_rdy_a[s]   = ra;
        iq.disp_rdy_b[s]   = rb;
        iq.disp_imm[s]     = imm;
        iq.disp_tag_rob[s] = tag;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        iq.ptr_old = 5'd0;
        step();
        step();
        check("rst_iss_valid", 32'(iq.iss_valid), 0);
        check("rst_free_cnt", 32'(iq.free_cnt), 8);
        check("rst_full", 32'(iq.full), 0);
        rst = 1'b0;

        // Three ready ADDs, tags 7,5,6 with head at 5: issue 5,6,7.
        iq.ptr_old = 5'd5;
        put(0, 2'd0, 5'd10, 5'd1, 5'd14, 1'b1, 1'b1, 5'd20, 5'd7);
        put(1, 2'd0, 5'd11, 5'd2, 5'd15, 1'b1, 1'b1, 5'd21, 5'd5);
        put(2, 2'd0, 5'd12, 5'd3, 5'd16, 1'b1, 1'b1, 5'd22, 5'd6);
        step();
        clear_in();
        check("age_disp_no_issue", 32'(iq.iss_valid), 0);
        check("age_free5", 32'(iq.free_cnt), 5);
        step();
        check("age_v1", 32'(iq.iss_valid), 1);
        check("age_tag1", 32'(iq.iss_tag_rob), 5);
        check("age_pa1", 32'(iq.iss_pa), 11);
        check("age_imm1", 32'(iq.iss_imm), 21);
        check("age_pw1", 32'(iq.iss_pw), 15);
        step();
        check("age_tag2", 32'(iq.iss_tag_rob), 6);
        check("age_free7", 32'(iq.free_cnt), 7);
        step();
        check("age_tag3", 32'(iq.iss_tag_rob), 7);
        step();
        check("age_drained", 32'(iq.iss_valid), 0);
        check("age_free8", 32'(iq.free_cnt), 8);

        // Reset mid-run with five entries valid.
        iq.ptr_old = 5'd10;
        put(0, 2'd0, 5'd20, 5'd1, 5'd1, 1'b0, 1'b1, 5'd0, 5'd10);
        put(1, 2'd0, 5'd20, 5'd1, 5'd1, 1'b0, 1'b1, 5'd0, 5'd11);
        put(2, 2'd0, 5'd20, 5'd1, 5'd1, 1'b0, 1'b1, 5'd0, 5'd12);
        step();
        clear_in();
        put(0, 2'd0, 5'd20, 5'd1, 5'd1, 1'b0, 1'b1, 5'd0, 5'd13);
        put(1, 2'd0, 5'd20, 5'd1, 5'd1, 1'b0, 1'b1, 5'd0, 5'd14);
        put(2, 2'd0, 5'd3,  5'd4, 5'd1, 1'b1, 1'b1, 5'd0, 5'd15);
        step();
        clear_in();
        check("pre_rst_full", 32'(iq.full), 1);
        step();
        check("pre_rst_valid", 32'(iq.iss_valid), 1);
        check("pre_rst_tag", 32'(iq.iss_tag_rob), 15);
        check("pre_rst_free", 32'(iq.free_cnt), 3);
        rst = 1'b1;
        step();
        check("mid_rst_valid", 32'(iq.iss_valid), 0);
        check("mid_rst_free", 32'(iq.free_cnt), 8);
        check("mid_rst_full", 32'(iq.full), 0);
        check("mid_rst_tag", 32'(iq.iss_tag_rob), 0);
        rst = 1'b0;

        // Full refuses the whole group; flush beats dispatch and wakeup.
        put(0, 2'd0, 5'd20, 5'd20, 5'd1, 1'b0, 1'b0, 5'd0, 5'd1);
        put(1, 2'd0, 5'd20, 5'd20, 5'd1, 1'b0, 1'b0, 5'd0, 5'd2);
        put(2, 2'd0, 5'd20, 5'd20, 5'd1, 1'b0, 1'b0, 5'd0, 5'd3);
        step();
        put(0, 2'd0, 5'd20, 5'd20, 5'd1, 1'b0, 1'b0, 5'd0, 5'd4);
        put(1, 2'd0, 5'd20, 5'd20, 5'd1, 1'b0, 1'b0, 5'd0, 5'd5);
        put(2, 2'd0, 5'd20, 5'd20, 5'd1, 1'b0, 1'b0, 5'd0, 5'd6);
        step();
        clear_in();
        check("full_free2", 32'(iq.free_cnt), 2);
        check("full_flag", 32'(iq.full), 1);
        put(0, 2'd0, 5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 5'd0, 5'd7);
        put(1, 2'd0, 5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 5'd0, 5'd8);
        put(2, 2'd0, 5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 5'd0, 5'd9);
        step();
        check("refused_free", 32'(iq.free_cnt), 2);
        check("refused_nvalid", 32'(iq.iss_valid), 0);
        iq.flush       = 1'b1;
        iq.wb_valid[0] = 1'b1;
        iq.wb_pw[0]    = 5'd20;
        step();
        clear_in();
        check("flush_free", 32'(iq.free_cnt), 8);
        check("flush_full", 32'(iq.full), 0);
        check("flush_nvalid", 32'(iq.iss_valid), 0);
        step();
        check("post_flush_nvalid", 32'(iq.iss_valid), 0);

        // Age wrap with head at 30; MUL slot ignored.
        iq.ptr_old = 5'd30;
        put(0, 2'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd0, 5'd1);
        put(1, 2'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd0, 5'd31);
        put(2, 2'd1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd0, 5'd9);
        step();
        clear_in();
        check("wrap_fu_filter", 32'(iq.free_cnt), 6);
        step();
        check("wrap_first", 32'(iq.iss_tag_rob), 31);
        step();
        check("wrap_second", 32'(iq.iss_tag_rob), 1);
        step();
        check("wrap_drained", 32'(iq.iss_valid), 0);

        // Broadcast wakeup latency: pa=9 woken on channel 2.
        iq.ptr_old = 5'd0;
        put(0, 2'd0, 5'd9, 5'd2, 5'd3, 1'b0, 1'b1, 5'd0, 5'd3);
        step();
        clear_in();
        step();
        check("wake_wait", 32'(iq.iss_valid), 0);
        iq.wb_valid[2] = 1'b1;
        iq.wb_pw[2]    = 5'd9;
        step();
        clear_in();
        check("wake_t1", 32'(iq.iss_valid), 32'(BYP));
        step();
        check("wake_t2", 32'(iq.iss_valid), 32'(!BYP));
        step();
        check("wake_drained", 32'(iq.iss_valid), 0);

        // Write-time wakeup: sources broadcast in the dispatch cycle.
        put(1, 2'd0, 5'd12, 5'd12, 5'd5, 1'b0, 1'b0, 5'd0, 5'd4);
        iq.wb_valid[0] = 1'b1;
        iq.wb_pw[0]    = 5'd12;
        step();
        clear_in();
        step();
        check("wtw_valid", 32'(iq.iss_valid), 1);
        check("wtw_tag", 32'(iq.iss_tag_rob), 4);

        // freeze_front blocks dispatch; freeze_back holds the issue packet.
        iq.freeze_front = 1'b1;
        put(0, 2'd0, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd0, 5'd9);
        step();
        clear_in();
        check("ffront_free", 32'(iq.free_cnt), 8);
        put(0, 2'd0, 5'd1, 5'd1, 5'd18, 1'b1, 1'b1, 5'd0, 5'd2);
        put(1, 2'd0, 5'd1, 5'd1, 5'd16, 1'b1, 1'b1, 5'd0, 5'd0);
        put(2, 2'd0, 5'd1, 5'd1, 5'd17, 1'b1, 1'b1, 5'd0, 5'd1);
        step();
        clear_in();
        step();
        check("fb_first", 32'(iq.iss_tag_rob), 0);
        iq.freeze_back = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("fb_hold_valid", 32'(iq.iss_valid), 1);
            check("fb_hold_tag", 32'(iq.iss_tag_rob), 0);
            check("fb_hold_pw", 32'(iq.iss_pw), 16);
            check("fb_hold_free", 32'(iq.free_cnt), 6);
        end
        iq.freeze_back = 1'b0;
        step();
        check("fb_resume1", 32'(iq.iss_tag_rob), 1);
        check("fb_resume1_free", 32'(iq.free_cnt), 7);
        step();
        check("fb_resume2", 32'(iq.iss_tag_rob), 2);
        check("fb_resume2_pw", 32'(iq.iss_pw), 18);
        check("fb_resume2_free", 32'(iq.free_cnt), 8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
